md_unit: RTL and testbench

MD_UNIT -- requirements
Module: md_unit

---
 rtl/md_unit_if.sv | 14 +
 rtl/md_unit.sv | 108 ++++++++++
 tb/tb_md_unit.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/md_unit_if.sv
// E-stage request bundle into the multiply/divide unit and its HI/LO/busy response.
// Requester drives start/op/a/b; the unit drives busy/hi/lo from registers only.
interface md_unit_if;
   logic        start;
   logic [2:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic        busy;
   logic [31:0] hi;
   logic [31:0] lo;

   modport master (output start, op, a, b, input busy, hi, lo);
   modport slave  (input start, op, a, b, output busy, hi, lo);
endinterface

// File: rtl/md_unit.sv
// Iterative-latency MIPS HI/LO unit: mult/div occupy MULT_CYCLES/DIV_CYCLES busy cycles, mthi/mtlo write at once.
// No backpressure: start is only honoured in IDLE; requests while busy, on completion, or with ops 6/7 are dropped.
module md_unit #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input logic      clk,
   input logic      reset,
   md_unit_if.slave md
);
   localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CW         = $clog2(MAX_CYCLES + 1);

   typedef enum logic {IDLE, RUN} state_t;

   state_t        state, state_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic [1:0]    op_q, op_nxt;
   logic [31:0]   a_q, a_nxt, b_q, b_nxt;
   logic [31:0]   hi_q, hi_nxt, lo_q, lo_nxt;

   logic [63:0]   ext_a, ext_b, prod;
   logic          a_neg, b_neg;
   logic [31:0]   a_mag, b_mag, divisor, q_mag, r_mag, quo, rem;

   // op_q[0] selects unsigned, op_q[1] selects divide; sign-extended 64-bit
   // operands give the correct two's-complement product for both mult flavours.
   always_comb begin
      ext_a   = {op_q[0] ? 32'd0 : {32{a_q[31]}}, a_q};
      ext_b   = {op_q[0] ? 32'd0 : {32{b_q[31]}}, b_q};
      prod    = ext_a * ext_b;
      a_neg   = ~op_q[0] & a_q[31];
      b_neg   = ~op_q[0] & b_q[31];
      a_mag   = a_neg ? (32'd0 - a_q) : a_q;
      b_mag   = b_neg ? (32'd0 - b_q) : b_q;
      divisor = (b_q == 32'd0) ? 32'd1 : b_mag;
      q_mag   = a_mag / divisor;
      r_mag   = a_mag % divisor;
      quo     = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
      rem     = a_neg ? (32'd0 - r_mag) : r_mag;
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      op_nxt    = op_q;
      a_nxt     = a_q;
      b_nxt     = b_q;
      hi_nxt    = hi_q;
      lo_nxt    = lo_q;
      unique case (state)
         IDLE: begin
            if (md.start) begin
               case (md.op)
                  3'd0, 3'd1, 3'd2, 3'd3: begin
                     state_nxt = RUN;
                     op_nxt    = md.op[1:0];
                     a_nxt     = md.a;
                     b_nxt     = md.b;
                     cnt_nxt   = md.op[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
                  end
                  3'd4:    hi_nxt = md.a;
                  3'd5:    lo_nxt = md.a;
                  default: ;
               endcase
            end
         end
         RUN: begin
            if (cnt == CW'(1)) begin
               state_nxt = IDLE;
               cnt_nxt   = '0;
               if (!op_q[1]) begin
                  {hi_nxt, lo_nxt} = prod;
               end else if (b_q != 32'd0) begin
                  hi_nxt = rem;
                  lo_nxt = quo;
               end
            end else begin
               cnt_nxt = cnt - CW'(1);
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= '0;
         op_q  <= '0;
         a_q   <= '0;
         b_q   <= '0;
         hi_q  <= '0;
         lo_q  <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         op_q  <= op_nxt;
         a_q   <= a_nxt;
         b_q   <= b_nxt;
         hi_q  <= hi_nxt;
         lo_q  <= lo_nxt;
      end
   end

   assign md.busy = (state == RUN);
   assign md.hi   = hi_q;
   assign md.lo   = lo_q;
endmodule

// File: tb/tb_md_unit.sv
// Scoreboard bench for md_unit: expected HI/LO and busy length are queued at launch and compared at completion.
module tb_md_unit;
   localparam int MC = 5;
   localparam int DC = 10;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   md_unit_if md ();

   md_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
      .clk   (clk),
      .reset (reset),
      .md    (md)
   );

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      int          cyc;
   } exp_t;

   exp_t        sb[$];
   int          checks = 0;
   int          errors = 0;
   logic [31:0] m_hi, m_lo;

   // Reference built from native 64-bit arithmetic.
   function automatic exp_t model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                  input logic [31:0] oh, input logic [31:0] ol);
      exp_t        e;
      longint      sa, sbv, p, q, r;
      logic [63:0] pu;
      e.hi = oh; e.lo = ol; e.cyc = 0;
      sa  = longint'($signed(a));
      sbv = longint'($signed(b));
      case (op)
         3'd0: begin p = sa * sbv; {e.hi, e.lo} = p; e.cyc = MC; end
         3'd1: begin pu = {32'd0, a} * {32'd0, b}; {e.hi, e.lo} = pu; e.cyc = MC; end
         3'd2: begin
            e.cyc = DC;
            if (b != 0) begin q = sa / sbv; r = sa % sbv; e.lo = q[31:0]; e.hi = r[31:0]; end
         end
         3'd3: begin
            e.cyc = DC;
            if (b != 0) begin e.lo = a / b; e.hi = a % b; end
         end
         default: ;
      endcase
      return e;
   endfunction

   // Called at a negedge: presents a request for one edge, then scrambles operands.
   task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      md.start = 1'b1; md.op = op; md.a = a; md.b = b;
      @(negedge clk);
      md.start = 1'b0; md.a = ~a; md.b = b ^ 32'h5A5A_0001;
   endtask

   // Counts consecutive busy samples from the current negedge (bounded).
   task automatic wait_busy(output int cyc);
      cyc = 0;
      while (md.busy === 1'b1 && cyc < 200) begin
         cyc++;
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; md.start = 1'b0; md.op = 3'd0; md.a = '0; md.b = '0;
      repeat (2) @(negedge clk);
      checks++; if (md.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", md.busy); end
      checks++; if (md.hi !== 32'd0) begin errors++; $display("FAIL reset_hi: got %h want 0", md.hi); end
      checks++; if (md.lo !== 32'd0) begin errors++; $display("FAIL reset_lo: got %h want 0", md.lo); end
      reset = 1'b0; m_hi = '0; m_lo = '0;
   endtask

   task automatic test_mult();
      logic [31:0] ta[2] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF};
      logic [31:0] tb[2] = '{32'd3,         32'hFFFF_FFFF};
      logic [31:0] th[2] = '{32'hFFFF_FFFF, 32'hFFFF_FFFE};
      logic [31:0] tl[2] = '{32'hFFFF_FFFA, 32'h0000_0001};
      int cyc;
      exp_t e;
      for (int i = 0; i < 2; i++) begin
         drive(3'(i), ta[i], tb[i]);
         sb.push_back('{th[i], tl[i], MC});
         wait_busy(cyc);
         e = sb.pop_front();
         checks++; if (cyc !== e.cyc) begin errors++; $display("FAIL mult_busy[%0d]: got %0d want %0d", i, cyc, e.cyc); end
         checks++; if (md.hi !== e.hi) begin errors++; $display("FAIL mult_hi[%0d]: got %h want %h", i, md.hi, e.hi); end
         checks++; if (md.lo !== e.lo) begin errors++; $display("FAIL mult_lo[%0d]: got %h want %h", i, md.lo, e.lo); end
         m_hi = e.hi; m_lo = e.lo;
      end
   endtask

   task automatic test_div();
      logic [2:0]  to[4] = '{3'd2, 3'd2, 3'd3, 3'd3};
      logic [31:0] ta[4] = '{32'hFFFF_FFF9, 32'h8000_0000, 32'd7, 32'd256};
      logic [31:0] tb[4] = '{32'd2,         32'hFFFF_FFFF, 32'd0, 32'd7};
      logic [31:0] th[4] = '{32'hFFFF_FFFF, 32'd0,         32'd0, 32'd4};
      logic [31:0] tl[4] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'd0, 32'h24};
      int cyc;
      exp_t e;
      for (int i = 0; i < 4; i++) begin
         drive(to[i], ta[i], tb[i]);
         if (tb[i] == 0) sb.push_back('{m_hi, m_lo, DC});
         else            sb.push_back('{th[i], tl[i], DC});
         wait_busy(cyc);
         e = sb.pop_front();
         checks++; if (cyc !== e.cyc) begin errors++; $display("FAIL div_busy[%0d]: got %0d want %0d", i, cyc, e.cyc); end
         checks++; if (md.hi !== e.hi) begin errors++; $display("FAIL div_hi[%0d]: got %h want %h", i, md.hi, e.hi); end
         checks++; if (md.lo !== e.lo) begin errors++; $display("FAIL div_lo[%0d]: got %h want %h", i, md.lo, e.lo); end
         m_hi = e.hi; m_lo = e.lo;
      end
   endtask

   task automatic test_mthi_mtlo();
      md.start = 1'b1; md.op = 3'd4; md.a = 32'h1234_5678;
      @(negedge clk);
      checks++; if (md.busy !== 1'b0) begin errors++; $display("FAIL mthi_busy: got %b want 0", md.busy); end
      checks++; if (md.hi !== 32'h1234_5678) begin errors++; $display("FAIL mthi_hi: got %h want 12345678", md.hi); end
      checks++; if (md.lo !== m_lo) begin errors++; $display("FAIL mthi_lo: got %h want %h", md.lo, m_lo); end
      md.op = 3'd5; md.a = 32'h9ABC_DEF0;
      @(negedge clk);
      md.start = 1'b0;
      checks++; if (md.busy !== 1'b0) begin errors++; $display("FAIL mtlo_busy: got %b want 0", md.busy); end
      checks++; if (md.hi !== 32'h1234_5678) begin errors++; $display("FAIL mtlo_hi: got %h want 12345678", md.hi); end
      checks++; if (md.lo !== 32'h9ABC_DEF0) begin errors++; $display("FAIL mtlo_lo: got %h want 9abcdef0", md.lo); end
      m_hi = 32'h1234_5678; m_lo = 32'h9ABC_DEF0;
   endtask

   task automatic test_reserved();
      for (int i = 6; i < 8; i++) begin
         md.start = 1'b1; md.op = 3'(i); md.a = 32'hDEAD_BEEF; md.b = 32'h1;
         @(negedge clk);
         md.start = 1'b0;
         checks++; if (md.busy !== 1'b0) begin errors++; $display("FAIL rsvd_busy[%0d]: got %b want 0", i, md.busy); end
         checks++; if ({md.hi, md.lo} !== {m_hi, m_lo}) begin errors++; $display("FAIL rsvd_hilo[%0d]: got %h_%h want %h_%h", i, md.hi, md.lo, m_hi, m_lo); end
      end
   endtask

   task automatic test_run_ignore();
      int cyc;
      exp_t e;
      drive(3'd2, 32'hFFFF_FF9C, 32'd7);
      sb.push_back('{32'hFFFF_FFFE, 32'hFFFF_FFF2, DC});
      repeat (2) @(negedge clk);
      md.start = 1'b1; md.op = 3'd5; md.a = 32'h1111_1111; md.b = 32'h2222_2222;
      @(negedge clk);
      md.start = 1'b0;
      checks++; if (md.lo !== m_lo) begin errors++; $display("FAIL run_mtlo_lo: got %h want %h", md.lo, m_lo); end
      wait_busy(cyc);
      cyc += 3;
      e = sb.pop_front();
      checks++; if (cyc !== e.cyc) begin errors++; $display("FAIL run_busy: got %0d want %0d", cyc, e.cyc); end
      checks++; if (md.hi !== e.hi) begin errors++; $display("FAIL run_hi: got %h want %h", md.hi, e.hi); end
      checks++; if (md.lo !== e.lo) begin errors++; $display("FAIL run_lo: got %h want %h", md.lo, e.lo); end
      m_hi = e.hi; m_lo = e.lo;
   endtask

   task automatic test_hold_start();
      int cyc;
      exp_t e;
      md.start = 1'b1; md.op = 3'd3; md.a = 32'd256; md.b = 32'd7;
      sb.push_back('{32'd4, 32'h24, DC});
      @(negedge clk);
      wait_busy(cyc);
      e = sb.pop_front();
      checks++; if (cyc !== e.cyc) begin errors++; $display("FAIL hold_busy: got %0d want %0d", cyc, e.cyc); end
      checks++; if ({md.hi, md.lo} !== {e.hi, e.lo}) begin errors++; $display("FAIL hold_hilo: got %h_%h want %h_%h", md.hi, md.lo, e.hi, e.lo); end
      @(negedge clk);
      md.start = 1'b0;
      checks++; if (md.busy !== 1'b1) begin errors++; $display("FAIL hold_relaunch: got %b want 1", md.busy); end
      wait_busy(cyc);
      m_hi = e.hi; m_lo = e.lo;
   endtask

   task automatic test_back_to_back();
      int cyc;
      exp_t e;
      drive(3'd0, 32'd7, 32'd9);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      checks++; if (md.busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", md.busy); end
      checks++; if ({md.hi, md.lo} !== 64'd0) begin errors++; $display("FAIL abort_hilo: got %h_%h want 0", md.hi, md.lo); end
      repeat (8) @(negedge clk);
      checks++; if ({md.busy, md.hi, md.lo} !== 65'd0) begin errors++; $display("FAIL abort_late: got %b %h_%h want 0", md.busy, md.hi, md.lo); end
      drive(3'd1, 32'h0001_0000, 32'h0001_0000);
      sb.push_back('{32'd1, 32'd0, MC});
      wait_busy(cyc);
      drive(3'd0, 32'd5, 32'hFFFF_FFFD);
      sb.push_back('{32'hFFFF_FFFF, 32'hFFFF_FFF1, MC});
      e = sb.pop_front();
      checks++; if (cyc !== e.cyc) begin errors++; $display("FAIL b2b0_busy: got %0d want %0d", cyc, e.cyc); end
      wait_busy(cyc);
      e = sb.pop_front();
      checks++; if (cyc !== e.cyc) begin errors++; $display("FAIL b2b1_busy: got %0d want %0d", cyc, e.cyc); end
      checks++; if ({md.hi, md.lo} !== {e.hi, e.lo}) begin errors++; $display("FAIL b2b1_hilo: got %h_%h want %h_%h", md.hi, md.lo, e.hi, e.lo); end
      m_hi = e.hi; m_lo = e.lo;
   endtask

   task automatic test_random();
      int          cyc;
      exp_t        e;
      logic [2:0]  op;
      logic [31:0] a, b;
      for (int i = 0; i < 24; i++) begin
         op = 3'($urandom_range(0, 3));
         a  = $urandom;
         b  = ($urandom_range(0, 7) == 0) ? 32'd0 : (($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(1, 300)));
         if (i == 0) begin op = 3'd2; a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
         drive(op, a, b);
         sb.push_back(model(op, a, b, m_hi, m_lo));
         wait_busy(cyc);
         e = sb.pop_front();
         checks++; if (cyc !== e.cyc) begin errors++; $display("FAIL rnd_busy[%0d]: got %0d want %0d", i, cyc, e.cyc); end
         checks++; if ({md.hi, md.lo} !== {e.hi, e.lo}) begin errors++; $display("FAIL rnd_hilo[%0d] op%0d a=%h b=%h: got %h_%h want %h_%h", i, op, a, b, md.hi, md.lo, e.hi, e.lo); end
         m_hi = e.hi; m_lo = e.lo;
      end
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_mult();
      test_div();
      test_mthi_mtlo();
      test_reserved();
      test_run_ignore();
      test_hold_start();
      test_back_to_back();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
